// File: rtl/argmin_pipe_pkg.sv
// Shared SGM helpers: constant clog2 and default sizing for the argmin reduction tree.
// Pure compile-time content; no latency, no flow control.
package argmin_pipe_pkg;

  localparam int DEFAULT_WIDTH  = 8;
  localparam int DEFAULT_INPUTS = 8;

  // Ceiling log2 for elaboration-time sizing; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = n - 1; v > 0; v = v >> 1) begin
      r = r + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/argmin_pipe_if.sv
// Bus bundle for argmin_pipe: packed input words with valid, registered min/argmin with valid.
// No backpressure: the producer drives one sample per cycle, the consumer must take every result.
interface argmin_pipe_if
  import argmin_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int INPUTS = DEFAULT_INPUTS
);

  localparam int IDX_WIDTH = clog2(INPUTS);

  logic                    in_valid;
  logic [WIDTH*INPUTS-1:0] input_words;
  logic                    out_valid;
  logic [WIDTH-1:0]        min_value;
  logic [IDX_WIDTH-1:0]    min_index;

  modport master (
    output in_valid,
    output input_words,
    input  out_valid,
    input  min_value,
    input  min_index
  );

  modport slave (
    input  in_valid,
    input  input_words,
    output out_valid,
    output min_value,
    output min_index
  );

endinterface

// File: rtl/argmin_pipe_node.sv
// Two-input registered compare-select; one cycle latency, no stall.
// Equal values resolve to the operand with the lower index.
module argmin_node #(
  parameter int WIDTH     = 8,
  parameter int IDX_WIDTH = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     a_val,
  input  logic [IDX_WIDTH-1:0] a_idx,
  input  logic [WIDTH-1:0]     b_val,
  input  logic [IDX_WIDTH-1:0] b_idx,
  output logic [WIDTH-1:0]     min_val,
  output logic [IDX_WIDTH-1:0] min_idx
);

  logic take_b;

  // The index compare keeps the rule local, so pad leaves lose ties wherever they sit.
  always_comb begin
    take_b = (b_val < a_val) || ((b_val == a_val) && (b_idx < a_idx));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      min_val <= '0;
      min_idx <= '0;
    end else begin
      min_val <= take_b ? b_val : a_val;
      min_idx <= take_b ? b_idx : a_idx;
    end
  end

endmodule

// File: rtl/argmin_pipe.sv
// Pipelined min/argmin over INPUTS unsigned words; latency clog2(INPUTS) cycles, one sample per cycle.
// No backpressure; the valid bit travels in a shift register beside the comparator tree.
module argmin_pipe
  import argmin_pipe_pkg::*;
#(
  parameter int WIDTH  = DEFAULT_WIDTH,
  parameter int INPUTS = DEFAULT_INPUTS
) (
  input logic         clk,
  input logic         rst,
  argmin_pipe_if.slave bus
);

  localparam int IDX_WIDTH = clog2(INPUTS);
  localparam int LEVELS    = clog2(INPUTS);
  localparam int LEAVES    = 1 << LEVELS;
  localparam int NODES     = 2 * LEAVES - 1;

  // Heap layout: node n has children 2n+1 / 2n+2, leaf j sits at LEAVES-1+j, root at 0.
  logic [WIDTH-1:0]     node_val [NODES];
  logic [IDX_WIDTH-1:0] node_idx [NODES];

  logic [LEVELS-1:0] vld_sr;

  generate
    for (genvar j = 0; j < LEAVES; j++) begin : g_leaf
      if (j < INPUTS) begin : g_real
        assign node_val[LEAVES-1+j] = bus.input_words[j*WIDTH +: WIDTH];
      end else begin : g_pad
        // All-ones with an index above every real word: never wins, even on a tie.
        assign node_val[LEAVES-1+j] = '1;
      end
      assign node_idx[LEAVES-1+j] = IDX_WIDTH'(j);
    end

    for (genvar n = 0; n < LEAVES - 1; n++) begin : g_node
      argmin_node #(
        .WIDTH     (WIDTH),
        .IDX_WIDTH (IDX_WIDTH)
      ) u_node (
        .clk     (clk),
        .rst     (rst),
        .a_val   (node_val[2*n+1]),
        .a_idx   (node_idx[2*n+1]),
        .b_val   (node_val[2*n+2]),
        .b_idx   (node_idx[2*n+2]),
        .min_val (node_val[n]),
        .min_idx (node_idx[n])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_sr <= '0;
    end else begin
      vld_sr[0] <= bus.in_valid;
      for (int i = 1; i < LEVELS; i++) begin
        vld_sr[i] <= vld_sr[i-1];
      end
    end
  end

  assign bus.out_valid = vld_sr[LEVELS-1];
  assign bus.min_value = node_val[0];
  assign bus.min_index = node_idx[0];

endmodule

// File: tb/tb_argmin_pipe.sv
// Bench for argmin_pipe: an 8x7-bit and a 5x4-bit instance, table vectors plus randomized
// traffic scored against a flat linear-scan min/argmin model delayed by the tree depth.
module tb_argmin_pipe;

  logic clk;
  logic rst_a;
  logic rst_b;

  int checks;
  int errors;

  argmin_pipe_if #(.WIDTH(7), .INPUTS(8)) bus_a ();
  argmin_pipe_if #(.WIDTH(4), .INPUTS(5)) bus_b ();

  argmin_pipe #(.WIDTH(7), .INPUTS(8)) dut_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  argmin_pipe #(.WIDTH(4), .INPUTS(5)) dut_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit vld;
    bit care;
    int val;
    int idx;
  } exp_t;

  typedef struct {
    logic [55:0] words;
    int          val;
    int          idx;
  } vec_t;

  localparam int LAT = 3;

  task automatic chk(input string name, input int act, input int req);
    checks = checks + 1;
    if (act != req) begin
      errors = errors + 1;
      $display("FAIL %s: actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Linear scan, strict less-than: the first (lowest-index) minimum is kept.
  function automatic exp_t model(input bit v, input logic [63:0] w, input int width, input int n);
    exp_t e;
    int best;
    int bi;
    int x;
    logic [63:0] mask;
    mask = (64'd1 << width) - 64'd1;
    best = int'(w & mask);
    bi   = 0;
    for (int i = 1; i < n; i++) begin
      x = int'((w >> (i * width)) & mask);
      if (x < best) begin
        best = x;
        bi   = i;
      end
    end
    e.vld  = v;
    e.care = v || (w == 64'd0);
    e.val  = best;
    e.idx  = bi;
    return e;
  endfunction

  function automatic exp_t zero_exp();
    exp_t e;
    e.vld = 1'b0; e.care = 1'b1; e.val = 0; e.idx = 0;
    return e;
  endfunction

  exp_t qa[$];
  exp_t qb[$];

  // Scoreboards: sample inputs at the edge, check outputs just after it.
  always @(posedge clk) begin : mon_a
    bit          r;
    bit          v;
    logic [63:0] w;
    exp_t        e;
    r = rst_a;
    v = bus_a.in_valid;
    w = 64'(bus_a.input_words);
    #1;
    if (r) begin
      qa.delete();
      for (int i = 0; i < LAT; i++) qa.push_back(zero_exp());
    end else begin
      qa.push_back(model(v, w, 7, 8));
    end
    if (qa.size() >= LAT) begin
      e = qa.pop_front();
      chk("sb_a_valid", int'(bus_a.out_valid), int'(e.vld));
      if (e.care) begin
        chk("sb_a_value", int'(bus_a.min_value), e.val);
        chk("sb_a_index", int'(bus_a.min_index), e.idx);
      end
    end
  end

  always @(posedge clk) begin : mon_b
    bit          r;
    bit          v;
    logic [63:0] w;
    exp_t        e;
    r = rst_b;
    v = bus_b.in_valid;
    w = 64'(bus_b.input_words);
    #1;
    if (r) begin
      qb.delete();
      for (int i = 0; i < LAT; i++) qb.push_back(zero_exp());
    end else begin
      qb.push_back(model(v, w, 4, 5));
    end
    if (qb.size() >= LAT) begin
      e = qb.pop_front();
      chk("sb_b_valid", int'(bus_b.out_valid), int'(e.vld));
      if (e.care) begin
        chk("sb_b_value", int'(bus_b.min_value), e.val);
        chk("sb_b_index", int'(bus_b.min_index), e.idx);
      end
    end
  end

  function automatic logic [55:0] rand_words_a(input int mode);
    logic [55:0] w;
    for (int i = 0; i < 8; i++) begin
      case (mode)
        0:       w[i*7 +: 7] = 7'($urandom_range(0, 2));
        1:       w[i*7 +: 7] = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : 7'h7f;
        default: w[i*7 +: 7] = 7'($urandom_range(0, 127));
      endcase
    end
    return w;
  endfunction

  function automatic logic [19:0] rand_words_b(input int mode);
    logic [19:0] w;
    for (int i = 0; i < 5; i++) begin
      case (mode)
        0:       w[i*4 +: 4] = 4'($urandom_range(0, 2));
        1:       w[i*4 +: 4] = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'hf;
        default: w[i*4 +: 4] = 4'($urandom_range(0, 15));
      endcase
    end
    return w;
  endfunction

  vec_t tbl[4];

  initial begin
    checks = 0;
    errors = 0;

    tbl[0].words = {7'd8, 7'd7, 7'd6, 7'd5, 7'd4, 7'd3, 7'd2, 7'd1};
    tbl[0].val = 1;   tbl[0].idx = 0;
    tbl[1].words = {7'd127, 7'd1, 7'd1, 7'd0, 7'd100, 7'd19, 7'd5, 7'd13};
    tbl[1].val = 0;   tbl[1].idx = 4;
    tbl[2].words = {8{7'd100}};
    tbl[2].val = 100; tbl[2].idx = 0;
    tbl[3].words = {7'd3, 7'd100, 7'd12, 7'd99, 7'd100, 7'd8, 7'd55, 7'd127};
    tbl[3].val = 3;   tbl[3].idx = 7;

    rst_a = 1'b1;
    rst_b = 1'b1;
    bus_a.in_valid    = 1'b0;
    bus_a.input_words = '0;
    bus_b.in_valid    = 1'b0;
    bus_b.input_words = '0;
    repeat (2) @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;

    // Idle after reset: everything reads zero.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("idle_valid", int'(bus_a.out_valid), 0);
      chk("idle_value", int'(bus_a.min_value), 0);
      chk("idle_index", int'(bus_a.min_index), 0);
    end

    // One vector at a time: result three cycles later, valid for exactly one cycle.
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      bus_a.in_valid    = 1'b1;
      bus_a.input_words = tbl[k].words;
      @(negedge clk);
      bus_a.in_valid    = 1'b0;
      bus_a.input_words = '0;
      repeat (2) @(negedge clk);
      chk("tbl_valid", int'(bus_a.out_valid), 1);
      chk("tbl_value", int'(bus_a.min_value), tbl[k].val);
      chk("tbl_index", int'(bus_a.min_index), tbl[k].idx);
      @(negedge clk);
      chk("tbl_valid_drop", int'(bus_a.out_valid), 0);
    end

    // Back-to-back stream: results emerge in order, one per cycle.
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      if (i >= LAT) begin
        chk("stream_valid", int'(bus_a.out_valid), 1);
        chk("stream_value", int'(bus_a.min_value), tbl[i-LAT].val);
        chk("stream_index", int'(bus_a.min_index), tbl[i-LAT].idx);
      end
      if (i < 4) begin
        bus_a.in_valid    = 1'b1;
        bus_a.input_words = tbl[i].words;
      end else begin
        bus_a.in_valid    = 1'b0;
        bus_a.input_words = '0;
      end
    end

    // Five all-ones words: real word 0 must beat the three all-ones pad leaves.
    @(negedge clk);
    bus_b.in_valid    = 1'b1;
    bus_b.input_words = 20'hfffff;
    @(negedge clk);
    bus_b.in_valid    = 1'b0;
    bus_b.input_words = '0;
    repeat (2) @(negedge clk);
    chk("pad_valid", int'(bus_b.out_valid), 1);
    chk("pad_value", int'(bus_b.min_value), 15);
    chk("pad_index", int'(bus_b.min_index), 0);

    // Reset in the middle of a stream: nothing stale may come out afterwards.
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus_b.in_valid    = 1'b1;
      bus_b.input_words = rand_words_b(2);
    end
    @(negedge clk);
    rst_b             = 1'b1;
    bus_b.input_words = rand_words_b(2);
    @(negedge clk);
    chk("rst_mid_valid", int'(bus_b.out_valid), 0);
    chk("rst_mid_value", int'(bus_b.min_value), 0);
    chk("rst_mid_index", int'(bus_b.min_index), 0);
    rst_b             = 1'b0;
    bus_b.in_valid    = 1'b0;
    bus_b.input_words = '0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("rst_no_stale", int'(bus_b.out_valid), 0);
    end

    // Randomized traffic on both instances, with occasional resets on the small one.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      bus_a.in_valid    = ($urandom_range(0, 3) != 0);
      bus_a.input_words = rand_words_a($urandom_range(0, 3));
      bus_b.in_valid    = ($urandom_range(0, 3) != 0);
      bus_b.input_words = rand_words_b($urandom_range(0, 3));
      rst_b             = ($urandom_range(0, 49) == 0);
    end
    @(negedge clk);
    rst_b             = 1'b0;
    bus_a.in_valid    = 1'b0;
    bus_a.input_words = '0;
    bus_b.in_valid    = 1'b0;
    bus_b.input_words = '0;
    repeat (6) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/argmin_pipe.md
Name: argmin_pipe

Overview:
Pipelined minimum/argmin reduction over INPUTS unsigned words presented as one packed vector. It returns the smallest value and the index of the word that holds it. It is a binary comparator tree with one register stage per tree level. It sits in the SGM cost-aggregation path to select the disparity with minimum cost.

Parameters:
WIDTH, 8, bit width of each unsigned input word.
INPUTS, 8, number of compared words; must be at least 2; need not be a power of two.
IDX_WIDTH, clog2(INPUTS), derived localparam giving the index width; 3 for the default.
LEVELS, clog2(INPUTS), derived localparam giving the tree depth, which equals the latency in cycles.

Ports:
clk  in  1  system clock; all state changes on the rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  input_words is valid this cycle.
input_words  in  WIDTH*INPUTS  packed array; word i occupies bits [i*WIDTH +: WIDTH], so word 0 is the LSBs.
out_valid  out  1  min_value and min_index are valid this cycle.
min_value  out  WIDTH  minimum of the words accepted LEVELS cycles earlier.
min_index  out  IDX_WIDTH  index of the word holding min_value.

Behaviour:
- Words are treated as unsigned.
- Reset: on a clk edge with rst=1, all valid bits in the pipeline clear to 0, min_value clears to 0 and min_index clears to 0. Any in-flight data is discarded; in_valid sampled on that same edge is ignored.
- Latency is exactly LEVELS cycles. A sample accepted at edge n appears on the outputs after edge n+LEVELS.
- Throughput is one sample per cycle. There is no backpressure and no stall input.
- out_valid is in_valid delayed by LEVELS cycles.
- Data registers update on every cycle regardless of valid. Outputs are don't-care while out_valid=0, except directly after reset, when they read 0.
- Tree structure: level 0 pairs words (2k, 2k+1). Each node outputs the smaller value and that value's index. Every node output is registered.
- Tie-break: when a < b is false and a == b, the node selects the lower-index operand. The overall result is therefore the lowest index among equal minima, e.g. all words equal gives min_index=0.
- Non-power-of-two INPUTS: pad the tree to 2^LEVELS leaves. Pad leaves use value all-ones and a pad index greater than every real index. Pad leaves can never win: a tie with a real all-ones word resolves to the real word by the lower-index rule.
- Index bits at node level L are formed by concatenating the winning child's select bit onto the child index. This is equivalent to carrying the full index.
- No overflow is possible; the design contains no arithmetic beyond comparison.

Decomposition:
- Shared package/include: clog2 constant function, also used by other SGM blocks.
- Sub-module argmin_node: 2-input registered compare-select with WIDTH and IDX_WIDTH parameters and clk/rst ports. It implements the lower-index-wins tie rule.
- argmin_pipe instantiates argmin_node in a generate loop per level and carries the valid shift register alongside.

Test Plan:
- Reset then in_valid=0 → out_valid=0, min_value=0, min_index=0 for all cycles.
- WIDTH=7, INPUTS=8, words 0..7 = 1,2,3,4,5,6,7,8 → after 3 cycles min_value=1, min_index=0, out_valid=1.
- Words 13,5,19,100,0,1,1,127 → min_value=0, min_index=4.
- All words 100 → min_value=100, min_index=0, per the lowest-index tie rule.
- Words 127,55,8,100,99,12,100,3 → min_value=3, min_index=7 (last-position and max-value coverage). Then stream the previous four vectors back-to-back for one vector per cycle; each result must appear in order, 3 cycles after its input.
- INPUTS=5, WIDTH=4, words 15,15,15,15,15 → min_index=0, with no pad leaf selected. Then assert rst mid-stream: out_valid must drop on the next edge and no stale results may emerge afterwards.
